div_booth_inv: RTL and testbench



---
 rtl/div_pkg.sv | 19 +
 rtl/div_dp.sv | 112 +++++++++++
 rtl/div_booth_inv.sv | 101 ++++++++++
 tb/tb_div_booth_inv.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding and
// the width of the step counter, which is derived from the operand width.
package div_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    SIGN = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic int cnt_width(input int bit_len);
    return $clog2(bit_len + 1);
  endfunction

endpackage

// File: rtl/div_dp.sv
// Divider datapath: operand capture, magnitude/sign split, restoring
// shift-subtract core, step counter and the registered quotient/remainder/flags.
module div_dp
  import div_pkg::*;
#(
  parameter int BIT_LEN = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_cap,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_accept,
  input  logic               i_sign,
  input  logic               i_set_bz,
  input  logic               i_set_ov,
  input  logic [BIT_LEN-1:0] i_in1,
  input  logic [BIT_LEN-1:0] i_in2,
  output logic               o_fin,
  output logic               o_bz,
  output logic               o_ov,
  output logic               o_t_neg,
  output logic [BIT_LEN-1:0] o_quo,
  output logic [BIT_LEN-1:0] o_rem,
  output logic               o_dbz,
  output logic               o_ovf
);

  localparam int CW = cnt_width(BIT_LEN);
  localparam logic [BIT_LEN-1:0] MOST_NEG = {1'b1, {(BIT_LEN-1){1'b0}}};

  logic [BIT_LEN-1:0] r_in1, r_in2, r_q, r_d, r_quo, r_rem;
  logic [BIT_LEN:0]   r_a;
  logic [CW-1:0]      r_cont;
  logic               r_sq, r_sr, r_dbz, r_ovf;

  logic [BIT_LEN-1:0] w_mag1, w_mag2;
  logic [BIT_LEN+1:0] w_a_sh, w_trial;
  logic [CW-1:0]      w_cont_dec;

  // The shifted partial remainder keeps A's top bit so the trial sign is exact.
  always_comb begin
    w_mag1     = r_in1[BIT_LEN-1] ? -r_in1 : r_in1;
    w_mag2     = r_in2[BIT_LEN-1] ? -r_in2 : r_in2;
    w_a_sh     = {r_a, r_q[BIT_LEN-1]};
    w_trial    = w_a_sh - {2'b00, r_d};
    w_cont_dec = r_cont - CW'(1);
    o_fin      = (w_cont_dec == '0);
    o_bz       = (r_in2 == '0);
    o_ov       = (r_in1 == MOST_NEG) && (r_in2 == '1);
    o_t_neg    = w_trial[BIT_LEN+1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_in1  <= '0;
      r_in2  <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_a    <= '0;
      r_cont <= '0;
      r_sq   <= 1'b0;
      r_sr   <= 1'b0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (i_cap) begin
        r_in1 <= i_in1;
        r_in2 <= i_in2;
      end
      if (i_load) begin
        r_sq   <= r_in1[BIT_LEN-1] ^ r_in2[BIT_LEN-1];
        r_sr   <= r_in1[BIT_LEN-1];
        r_q    <= w_mag1;
        r_d    <= w_mag2;
        r_a    <= '0;
        r_cont <= CW'(BIT_LEN);
      end
      if (i_set_bz) begin
        r_dbz <= 1'b1;
        r_ovf <= 1'b0;
        r_quo <= '1;
        r_rem <= r_in1;
      end
      if (i_set_ov) begin
        r_dbz <= 1'b0;
        r_ovf <= 1'b1;
        r_quo <= MOST_NEG;
        r_rem <= '0;
      end
      if (i_step) begin
        r_a    <= i_accept ? w_trial[BIT_LEN:0] : w_a_sh[BIT_LEN:0];
        r_q    <= {r_q[BIT_LEN-2:0], i_accept};
        r_cont <= w_cont_dec;
      end
      if (i_sign) begin
        r_quo <= r_sq ? -r_q : r_q;
        r_rem <= r_sr ? -r_a[BIT_LEN-1:0] : r_a[BIT_LEN-1:0];
        r_dbz <= 1'b0;
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_quo = r_quo;
  assign o_rem = r_rem;
  assign o_dbz = r_dbz;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/div_booth_inv.sv
// Sequential signed divider (truncating quotient, dividend-signed remainder)
// with the Booth multiplier's start/out_r handshake; control FSM lives here.
module div_booth_inv
  import div_pkg::*;
#(
  parameter int BIT_LEN = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [BIT_LEN-1:0] in1,
  input  logic [BIT_LEN-1:0] in2,
  output logic [BIT_LEN-1:0] quo,
  output logic [BIT_LEN-1:0] rem,
  output logic               out_r,
  output logic               dbz,
  output logic               ovf
);

  state_t r_state, w_nxt;
  logic   r_out_r;
  logic   w_cap, w_load, w_step, w_accept, w_sign, w_set_bz, w_set_ov;
  logic   w_fin, w_bz, w_ov, w_t_neg;

  div_dp #(.BIT_LEN(BIT_LEN)) dp (
    .clk      (clk),
    .rstn     (rstn),
    .i_cap    (w_cap),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_accept (w_accept),
    .i_sign   (w_sign),
    .i_set_bz (w_set_bz),
    .i_set_ov (w_set_ov),
    .i_in1    (in1),
    .i_in2    (in2),
    .o_fin    (w_fin),
    .o_bz     (w_bz),
    .o_ov     (w_ov),
    .o_t_neg  (w_t_neg),
    .o_quo    (quo),
    .o_rem    (rem),
    .o_dbz    (dbz),
    .o_ovf    (ovf)
  );

  always_comb begin
    w_nxt    = r_state;
    w_cap    = 1'b0;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_accept = 1'b0;
    w_sign   = 1'b0;
    w_set_bz = 1'b0;
    w_set_ov = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_cap = 1'b1;
          w_nxt = LOAD;
        end
      end
      LOAD: begin
        w_load = 1'b1;
        if (w_bz) begin
          w_set_bz = 1'b1;
          w_nxt    = DONE;
        end else if (w_ov) begin
          w_set_ov = 1'b1;
          w_nxt    = DONE;
        end else begin
          w_nxt = CALC;
        end
      end
      CALC: begin
        w_step   = 1'b1;
        w_accept = ~w_t_neg;
        if (w_fin) w_nxt = SIGN;
      end
      SIGN: begin
        w_sign = 1'b1;
        w_nxt  = DONE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // out_r is registered from the next state so it rises on the edge entering DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_out_r <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_out_r <= (w_nxt == DONE);
    end
  end

  assign out_r = r_out_r;

endmodule

// File: tb/tb_div_booth_inv.sv
// Self-checking bench for div_booth_inv at BIT_LEN=4: directed vector table,
// handshake corner sequences and an exhaustive sweep against a behavioural model.
module tb_div_booth_inv;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [3:0] in1, in2;
  logic [3:0] quo, rem;
  logic       out_r, dbz, ovf;

  int checks = 0;
  int errors = 0;

  div_booth_inv #(.BIT_LEN(4)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .quo   (quo),
    .rem   (rem),
    .out_r (out_r),
    .dbz   (dbz),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
    logic       o;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Pulse start for one edge, then count edges until out_r is seen high.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in1   = 4'($urandom);
    in2   = 4'($urandom);
    check("out_r_low_after_capture", {31'd0, out_r}, 32'd0);
    lat = 1;
    while (out_r !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic signed [3:0] sa, sb;
    logic [3:0] eq, er;
    logic       ez, eo;
    int         elat;

    vecs[0]  = '{4'h7, 4'hB, 4'hF, 4'h2, 1'b0, 1'b0, 7};  //  7 / -5
    vecs[1]  = '{4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0, 7};  // -7 /  2
    vecs[2]  = '{4'h6, 4'h3, 4'h2, 4'h0, 1'b0, 1'b0, 7};  //  6 /  3 from DONE
    vecs[3]  = '{4'h5, 4'h0, 4'hF, 4'h5, 1'b1, 1'b0, 2};  //  5 /  0
    vecs[4]  = '{4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1, 2};  // -8 / -1
    vecs[5]  = '{4'h8, 4'h3, 4'hE, 4'hE, 1'b0, 1'b0, 7};  // -8 /  3
    vecs[6]  = '{4'hF, 4'h2, 4'h0, 4'hF, 1'b0, 1'b0, 7};  // -1 /  2
    vecs[7]  = '{4'h3, 4'h8, 4'h0, 4'h3, 1'b0, 1'b0, 7};  //  3 / -8
    vecs[8]  = '{4'h8, 4'h8, 4'h1, 4'h0, 1'b0, 1'b0, 7};  // -8 / -8
    vecs[9]  = '{4'h8, 4'h7, 4'hF, 4'hF, 1'b0, 1'b0, 7};  // -8 /  7
    vecs[10] = '{4'h7, 4'hF, 4'h9, 4'h0, 1'b0, 1'b0, 7};  //  7 / -1
    vecs[11] = '{4'h0, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0, 7};  //  0 /  5

    rstn  = 1'b0;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    #12;
    check("reset_outputs", {20'd0, quo, rem, out_r, dbz, ovf, 1'b0}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("idle_out_r", {31'd0, out_r}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_quo", i), {28'd0, quo}, {28'd0, vecs[i].q});
      check($sformatf("vec%0d_rem", i), {28'd0, rem}, {28'd0, vecs[i].r});
      check($sformatf("vec%0d_flags", i), {30'd0, dbz, ovf}, {30'd0, vecs[i].z, vecs[i].o});
    end

    // Result must hold in DONE while start stays low.
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", {23'd0, out_r, quo, rem}, {23'd0, 1'b1, 4'h0, 4'h0});

    // start pulses while busy are ignored: 6/3 keeps its latency and result.
    @(negedge clk);
    in1 = 4'h6; in2 = 4'h3; start = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    while (out_r !== 1'b1 && lat < 20) begin
      @(negedge clk);
      start = 1'b1; in1 = 4'h5; in2 = 4'h1;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("busy_start_latency", lat, 7);
    check("busy_start_quo", {28'd0, quo}, 32'd2);
    check("busy_start_rem", {28'd0, rem}, 32'd0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    in1 = 4'h7; in2 = 4'h2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_outputs", {20'd0, quo, rem, out_r, dbz, ovf, 1'b0}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("after_reset_idle", {31'd0, out_r}, 32'd0);
    do_op(4'h7, 4'h2, lat);
    check("after_reset_latency", lat, 7);
    check("after_reset_result", {24'd0, quo, rem}, {24'd0, 4'h3, 4'h1});

    // Exhaustive sweep against a behavioural signed-division model.
    for (int i = 0; i < 256; i++) begin
      sa = 4'(i >> 4);
      sb = 4'(i);
      if (sb == 4'sd0) begin
        eq = 4'hF; er = sa; ez = 1'b1; eo = 1'b0; elat = 2;
      end else if (sa == -4'sd8 && sb == -4'sd1) begin
        eq = 4'h8; er = 4'h0; ez = 1'b0; eo = 1'b1; elat = 2;
      end else begin
        eq = sa / sb; er = sa % sb; ez = 1'b0; eo = 1'b0; elat = 7;
      end
      do_op(sa, sb, lat);
      check($sformatf("sweep_%0d_%0d_latency", sa, sb), lat, elat);
      check($sformatf("sweep_%0d_%0d_result", sa, sb),
            {22'd0, quo, rem, dbz, ovf}, {22'd0, eq, er, ez, eo});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
